// File: rtl/bird_datapath_pkg.sv
// Shared constants for the bird controller/datapath pair: state codes, geometry, colours.
package bird_datapath_pkg;

    localparam int unsigned X_POS     = 20;
    localparam int unsigned SIZE      = 4;
    localparam int unsigned Y_START   = 60;
    localparam int unsigned Y_TOP     = 10;
    localparam int unsigned Y_GROUND  = 116;
    localparam int unsigned RISE_STEP = 2;
    localparam int unsigned FALL_STEP = 1;
    localparam int unsigned RISE_LEN  = 8;

    localparam int unsigned SCREEN_W  = 160;
    localparam int unsigned SCREEN_H  = 120;

    localparam int unsigned X_W       = 8;
    localparam int unsigned Y_W       = 7;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned COLOUR_W  = 3;
    localparam int unsigned SCAN_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned RC_W      = $clog2(RISE_LEN + 1);

    localparam logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000;
    localparam logic [COLOUR_W-1:0] BIRD_COLOUR = 3'b110;

    localparam logic [STATE_W-1:0] ST_START   = 4'd0;
    localparam logic [STATE_W-1:0] ST_RAISING = 4'd1;
    localparam logic [STATE_W-1:0] ST_FALLING = 4'd2;
    localparam logic [STATE_W-1:0] ST_STOP    = 4'd3;
    localparam logic [STATE_W-1:0] ST_DRAW    = 4'd4;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_ERASE = 2'd1,
        D_DRAW  = 2'd2
    } draw_state_e;

endpackage

// File: rtl/bird_datapath_sprite_scan.sv
// Raster counter over a SIZE x SIZE sprite; cx is the fast index.
// Exposes the next index so the caller can register pixel coordinates in step with it.
module bird_datapath_sprite_scan #(
    parameter int unsigned SIZE = 4,
    parameter int unsigned CW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          en,
    output logic [CW-1:0] cx,
    output logic [CW-1:0] cy,
    output logic [CW-1:0] cx_nxt_c,
    output logic [CW-1:0] cy_nxt_c,
    output logic          last
);

    localparam logic [CW-1:0] MAX = CW'(SIZE - 1);

    always_comb begin
        cx_nxt_c = cx;
        cy_nxt_c = cy;
        if (start) begin
            cx_nxt_c = '0;
            cy_nxt_c = '0;
        end else if (en) begin
            if (cx == MAX) begin
                cx_nxt_c = '0;
                cy_nxt_c = (cy == MAX) ? '0 : cy + 1'b1;
            end else begin
                cx_nxt_c = cx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cx   <= '0;
            cy   <= '0;
            last <= 1'b0;
        end else begin
            cx   <= cx_nxt_c;
            cy   <= cy_nxt_c;
            last <= (cx_nxt_c == MAX) && (cy_nxt_c == MAX);
        end
    end

endmodule

// File: rtl/bird_datapath.sv
// Bird datapath: vertical physics and rise counter driven by the controller state code,
// plus an erase/redraw pixel sequencer for the VGA adapter.
module bird_datapath
    import bird_datapath_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [STATE_W-1:0]  state,
    input  logic                step_en,
    input  logic                pipe_hit,
    output logic                flag,
    output logic                touched,
    output logic [Y_W-1:0]      bird_y,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy
);

    localparam logic [RC_W:0] RL_EXT = (RC_W + 1)'(RISE_LEN);

    logic [RC_W-1:0]   rise_cnt;
    logic [RC_W:0]     rc_inc;
    logic [Y_W-1:0]    ny;
    logic [Y_W-1:0]    by_nxt;
    logic              trig;

    draw_state_e       d_state, d_nxt;
    logic              pending, pending_nxt;
    logic [Y_W-1:0]    drawn_y, drawn_y_nxt;
    logic [Y_W-1:0]    old_y, old_y_nxt;
    logic [Y_W-1:0]    new_y, new_y_nxt;
    logic [Y_W-1:0]    y_base;
    logic              plot_nxt;
    logic [X_W-1:0]    vga_x_nxt;
    logic [Y_W-1:0]    vga_y_nxt;
    logic [COLOUR_W-1:0] colour_nxt;

    logic              scan_start, scan_en, scan_last;
    logic [SCAN_W-1:0] cx, cy, cx_nxt, cy_nxt;

    // Candidate position: saturating compares are done before the add/subtract so y never wraps.
    always_comb begin
        ny     = bird_y;
        rc_inc = {1'b0, rise_cnt} + 1'b1;
        case (state)
            ST_START:   ny = Y_W'(Y_START);
            ST_RAISING: ny = (bird_y <= Y_W'(Y_TOP + RISE_STEP)) ? Y_W'(Y_TOP)
                                                                 : bird_y - Y_W'(RISE_STEP);
            ST_FALLING: ny = (bird_y >= Y_W'(Y_GROUND - FALL_STEP)) ? Y_W'(Y_GROUND)
                                                                    : bird_y + Y_W'(FALL_STEP);
            default:    ny = bird_y;
        endcase
        trig   = step_en && ((state == ST_START) || (ny != bird_y));
        by_nxt = step_en ? ny : bird_y;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bird_y   <= Y_W'(Y_START);
            rise_cnt <= '0;
            flag     <= 1'b0;
            touched  <= 1'b0;
        end else if (step_en) begin
            bird_y <= ny;
            case (state)
                ST_START: begin
                    rise_cnt <= '0;
                    flag     <= 1'b0;
                    touched  <= 1'b0;
                end
                ST_RAISING: begin
                    rise_cnt <= (rc_inc >= RL_EXT) ? RC_W'(RISE_LEN) : rc_inc[RC_W-1:0];
                    flag     <= (rc_inc >= RL_EXT) || (ny == Y_W'(Y_TOP));
                    touched  <= pipe_hit;
                end
                ST_FALLING: begin
                    rise_cnt <= '0;
                    flag     <= 1'b0;
                    touched  <= (ny == Y_W'(Y_GROUND)) || pipe_hit;
                end
                default: ;
            endcase
        end
    end

    bird_datapath_sprite_scan #(.SIZE(SIZE), .CW(SCAN_W)) u_scan (
        .clk      (clk),
        .resetn   (resetn),
        .start    (scan_start),
        .en       (scan_en),
        .cx       (cx),
        .cy       (cy),
        .cx_nxt_c (cx_nxt),
        .cy_nxt_c (cy_nxt),
        .last     (scan_last)
    );

    // Draw sequencer state register.
    always_ff @(posedge clk) begin
        if (!resetn) d_state <= D_IDLE;
        else         d_state <= d_nxt;
    end

    // Next state; a pending move chains straight from the last DRAW pixel into a new ERASE.
    always_comb begin
        d_nxt      = d_state;
        scan_start = 1'b0;
        scan_en    = 1'b0;
        case (d_state)
            D_IDLE: begin
                if (trig) begin
                    d_nxt      = D_ERASE;
                    scan_start = 1'b1;
                end
            end
            D_ERASE: begin
                if (scan_last) begin
                    d_nxt      = D_DRAW;
                    scan_start = 1'b1;
                end else begin
                    scan_en = 1'b1;
                end
            end
            D_DRAW: begin
                if (scan_last) begin
                    if (pending || trig) begin
                        d_nxt      = D_ERASE;
                        scan_start = 1'b1;
                    end else begin
                        d_nxt = D_IDLE;
                    end
                end else begin
                    scan_en = 1'b1;
                end
            end
            default: d_nxt = D_IDLE;
        endcase
    end

    // Sequencer outputs: the pixel to present after the coming edge.
    always_comb begin
        old_y_nxt   = old_y;
        new_y_nxt   = new_y;
        drawn_y_nxt = drawn_y;
        pending_nxt = pending;
        if ((d_state != D_IDLE) && trig) pending_nxt = 1'b1;
        if ((d_state == D_DRAW) && scan_last) begin
            drawn_y_nxt = new_y;
            pending_nxt = 1'b0;
        end
        if (scan_start && (d_nxt == D_ERASE)) begin
            old_y_nxt = (d_state == D_DRAW) ? new_y : drawn_y;
            new_y_nxt = by_nxt;
        end
        plot_nxt   = (d_nxt != D_IDLE);
        colour_nxt = (d_nxt == D_DRAW) ? BIRD_COLOUR : BG_COLOUR;
        y_base     = (d_nxt == D_DRAW) ? new_y_nxt : old_y_nxt;
        vga_x_nxt  = X_W'(X_POS) + X_W'(cx_nxt);
        vga_y_nxt  = y_base + Y_W'(cy_nxt);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending <= 1'b0;
            drawn_y <= Y_W'(Y_START);
            old_y   <= Y_W'(Y_START);
            new_y   <= Y_W'(Y_START);
            plot    <= 1'b0;
            busy    <= 1'b0;
            vga_x   <= '0;
            vga_y   <= '0;
            colour  <= '0;
        end else begin
            pending <= pending_nxt;
            drawn_y <= drawn_y_nxt;
            old_y   <= old_y_nxt;
            new_y   <= new_y_nxt;
            plot    <= plot_nxt;
            busy    <= plot_nxt;
            if (plot_nxt) begin
                vga_x  <= vga_x_nxt;
                vga_y  <= vga_y_nxt;
                colour <= colour_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bird_datapath.sv
// Scoreboard bench for bird_datapath: physics checked per step, every plotted pixel
// checked against an expected-pixel queue filled when the step is driven.
module tb_bird_datapath;
    import bird_datapath_pkg::*;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [3:0]   state = 4'd0;
    logic         step_en = 1'b0;
    logic         pipe_hit = 1'b0;
    logic         flag, touched, plot, busy;
    logic [6:0]   bird_y, vga_y;
    logic [7:0]   vga_x;
    logic [2:0]   colour;

    bird_datapath dut (
        .clk(clk), .resetn(resetn), .state(state), .step_en(step_en), .pipe_hit(pipe_hit),
        .flag(flag), .touched(touched), .bird_y(bird_y), .vga_x(vga_x), .vga_y(vga_y),
        .colour(colour), .plot(plot), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    logic [17:0] exp_q[$];
    bit          chk_en = 1'b1;
    int          plot_cnt = 0;
    int          busy_run = 0;
    int          last_run = 0;

    // Model state
    int m_y = Y_START;
    int m_rc = 0;
    bit m_flag = 0;
    bit m_touch = 0;
    int m_q_new = Y_START;

    always @(negedge clk) begin
        logic [17:0] e;
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
        if (plot) plot_cnt++;
        if (plot && chk_en) begin
            if (exp_q.size() == 0) check("pix_extra", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("pix", {14'b0, vga_x, vga_y, colour}, {14'b0, e});
            end
        end
    end

    task automatic push_sprite(input int y, input logic [2:0] c);
        logic [17:0] v;
        for (int cy = 0; cy < SIZE; cy++)
            for (int cx = 0; cx < SIZE; cx++) begin
                v = {8'(X_POS + cx), 7'(y + cy), c};
                exp_q.push_back(v);
            end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'd0, 32'd1);
        check("pix_missing", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_step(input logic [3:0] s, input logic ph, input bit wt);
        int ny;
        bit trig;
        ny = m_y;
        if (s == ST_START) ny = Y_START;
        else if (s == ST_RAISING) ny = (m_y - int'(RISE_STEP) < int'(Y_TOP)) ? Y_TOP : m_y - RISE_STEP;
        else if (s == ST_FALLING) ny = (m_y + int'(FALL_STEP) > int'(Y_GROUND)) ? Y_GROUND : m_y + FALL_STEP;
        trig = (s == ST_START) || (ny != m_y);
        if (s == ST_START) begin
            m_rc = 0; m_flag = 0; m_touch = 0;
        end else if (s == ST_RAISING) begin
            m_flag  = (m_rc + 1 >= int'(RISE_LEN)) || (ny == int'(Y_TOP));
            m_rc    = (m_rc + 1 > int'(RISE_LEN)) ? RISE_LEN : m_rc + 1;
            m_touch = ph;
        end else if (s == ST_FALLING) begin
            m_rc = 0; m_flag = 0;
            m_touch = (ny == int'(Y_GROUND)) || ph;
        end
        m_y = ny;

        @(negedge clk);
        state = s; pipe_hit = ph; step_en = 1'b1;
        if (trig) begin
            push_sprite(m_q_new, BG_COLOUR);
            push_sprite(ny, BIRD_COLOUR);
            m_q_new = ny;
        end
        @(negedge clk);
        step_en = 1'b0; pipe_hit = 1'b0; state = ST_DRAW;
        check("bird_y", 32'(bird_y), 32'(m_y));
        check("flag", 32'(flag), 32'(m_flag));
        check("touched", 32'(touched), 32'(m_touch));
        if (wt) begin
            check("plot_start", 32'(plot), 32'(trig));
            wait_idle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_bird_y", 32'(bird_y), 32'd60);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_touched", 32'(touched), 32'd0);
        check("rst_vga", {13'b0, vga_x, vga_y, colour}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: START draw, 32 pixels, busy timing
        plot_cnt = 0;
        do_step(ST_START, 1'b0, 1'b0);
        check("t1_plot_first", 32'(plot), 32'd1);
        check("t1_busy_first", 32'(busy), 32'd1);
        repeat (31) @(negedge clk);
        check("t1_busy_pix32", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_busy_drop", 32'(busy), 32'd0);
        check("t1_plot_drop", 32'(plot), 32'd0);
        check("t1_plot_cnt", 32'(plot_cnt), 32'd32);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // 2: eight rises from 60
        for (int i = 0; i < 8; i++) do_step(ST_RAISING, 1'b0, 1'b1);
        check("t2_y44", 32'(bird_y), 32'd44);

        // 3: top saturation
        do_step(ST_START, 1'b0, 1'b1);
        for (int i = 0; i < 23; i++) do_step(ST_RAISING, 1'b0, 1'b1);
        check("t3_y14", 32'(bird_y), 32'd14);
        for (int i = 0; i < 3; i++) do_step(ST_RAISING, 1'b0, 1'b1);
        check("t3_y10", 32'(bird_y), 32'd10);
        check("t3_flag", 32'(flag), 32'd1);

        // 5: pipe hit while falling
        do_step(ST_START, 1'b0, 1'b1);
        do_step(ST_RAISING, 1'b0, 1'b1);
        do_step(ST_FALLING, 1'b0, 1'b1);
        do_step(ST_FALLING, 1'b0, 1'b1);
        do_step(ST_FALLING, 1'b1, 1'b1);
        check("t5_y61", 32'(bird_y), 32'd61);
        check("t5_touched", 32'(touched), 32'd1);
        check("t5_rise_cnt", 32'(dut.rise_cnt), 32'd0);

        // Hold states leave physics alone
        do_step(ST_STOP, 1'b0, 1'b1);
        do_step(4'd9, 1'b0, 1'b1);

        // 4: ground saturation
        do_step(ST_START, 1'b0, 1'b1);
        for (int i = 0; i < 53; i++) do_step(ST_FALLING, 1'b0, 1'b1);
        check("t4_y113", 32'(bird_y), 32'd113);
        for (int i = 0; i < 4; i++) do_step(ST_FALLING, 1'b0, 1'b1);
        check("t4_y116", 32'(bird_y), 32'd116);
        check("t4_touched", 32'(touched), 32'd1);

        // 6: overlapping moves chain without an idle gap
        do_step(ST_START, 1'b0, 1'b1);
        do_step(ST_RAISING, 1'b0, 1'b0);
        @(negedge clk);
        do_step(ST_RAISING, 1'b0, 1'b0);
        wait_idle();
        @(negedge clk);
        check("t6_busy_run", 32'(last_run), 32'd64);
        check("t6_y56", 32'(bird_y), 32'd56);

        // Reset in the middle of a draw
        do_step(ST_RAISING, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        check("rst_mid_plot", 32'(plot), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_y", 32'(bird_y), 32'd60);
        resetn = 1'b1;
        exp_q.delete();
        m_y = Y_START; m_rc = 0; m_flag = 0; m_touch = 0; m_q_new = Y_START;
        @(negedge clk);
        chk_en = 1'b1;
        do_step(ST_START, 1'b0, 1'b1);
        do_step(ST_FALLING, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
